dvp_frame_gen: RTL and testbench
================================

# dvp_frame_gen

Synthetic DVP camera source that drives the same 8-bit vsync/href/data interface an OV5640 presents to the capture path. It produces RGB565 frames, two bytes per pixel, one byte per clock. Test patterns are selectable. The block replaces the sensor in bring-up and regression, so the capture-to-DDR datapath can be checked against known pixel values without live optics.

## Interface
Parameters:
- H_ACTIVE, 640: active pixels per line; must be a multiple of 8 and ≥ 8.
- V_ACTIVE, 480: active lines per frame; ≥ 1.
- H_BLANK, 144: href-low clocks after every line; ≥ 1.
- VSYNC_LEN, 8: clocks vsync is held high; ≥ 1.
- V_BACK, 32: clocks from vsync fall to the first href; ≥ 1.
- V_FRONT, 16: clocks after the last line's blanking to frame end; ≥ 1.

Ports:
- clk_25m, in, 1: sole clock; data advances one byte per cycle.
- sys_rst, in, 1: reset, synchronous and active-high.
- enable, in, 1: run request; sampled at the frame boundary.
- pattern_sel, in, 2: 0 colour bars, 1 x-ramp, 2 {y,x} counter, 3 solid.
- solid_rgb, in, 16: RGB565 value used by pattern 3.
- dvp_vsync, out, 1: frame sync, active-high.
- dvp_href, out, 1: line valid, active-high.
- dvp_d, out, 8: pixel byte.
- busy, out, 1: high whenever the FSM is not in IDLE.
- frame_done, out, 1: one-cycle pulse at frame end.
- frame_cnt, out, 16: completed-frame count; wraps at 0xFFFF→0.

## Operation
FSM states and transitions:
- IDLE → VSYNC when enable = 1.
- VSYNC lasts VSYNC_LEN cycles, then → VBACK.
- VBACK lasts V_BACK cycles, then → LINE.
- LINE lasts 2·H_ACTIVE cycles, then → HBLANK.
- HBLANK lasts H_BLANK cycles; from HBLANK go → LINE if y < V_ACTIVE−1, else → VFRONT.
- VFRONT lasts V_FRONT cycles; from VFRONT go → VSYNC if enable = 1, else → IDLE.

Output behaviour:
- All outputs are registered.
- dvp_vsync is high only in VSYNC.
- dvp_href is high only in LINE.
- dvp_d = 0x00 whenever dvp_href = 0.
- Within a pixel, the high byte goes out first, then the low byte.
- x counts 0..H_ACTIVE−1 and y counts 0..V_ACTIVE−1.
- pattern_sel and solid_rgb are latched on entry to VSYNC and held for the whole frame; mid-frame changes are ignored.

Patterns:
- 0, colour bars: 8 equal bars of H_ACTIVE/8 pixels, in order FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
- 1, x-ramp: pixel = x[15:0], zero-extended.
- 2, counter: pixel = {y[7:0], x[7:0]}.
- 3, solid: pixel = latched solid_rgb.

Boundary conditions:
- Deasserting enable mid-frame lets the current frame complete; it never truncates.
- frame_done pulses during the last VFRONT cycle; frame_cnt shows the incremented value one cycle later.
- Back-to-back frames: VSYNC immediately follows VFRONT, with no IDLE cycle.
- Reset at any time returns the FSM to IDLE and forces every output to 0 on the next edge; frame_cnt clears to 0.
- Counter widths are $clog2 of the respective maximum, with a minimum of 1.

## Timing
- enable is sampled high in IDLE at edge k; dvp_vsync = 1 is visible from cycle k+1.
- First dvp_href rise occurs VSYNC_LEN + V_BACK cycles after the vsync rise.
- One frame period = VSYNC_LEN + V_BACK + V_ACTIVE·(2·H_ACTIVE + H_BLANK) + V_FRONT cycles.
- dvp_d, dvp_href and dvp_vsync change on the same edge and are stable for a full cycle.
- A receiver samples them with cmos_pclk driven from clk_25m.

## Structure
- Package dvp_pkg holds:
  - the FSM state enum: IDLE, VSYNC, VBACK, LINE, HBLANK, VFRONT;
  - the PAT_BARS/PAT_XRAMP/PAT_CNT/PAT_SOLID codes;
  - the eight RGB565 bar constants.
- One sub-module, dvp_pixel_src, is combinational: (pattern, x, y, solid) → 16-bit pixel.
- The top level registers the byte mux and the syncs.

## Test plan
All scenarios use H_ACTIVE=8, V_ACTIVE=2, H_BLANK=4, VSYNC_LEN=3, V_BACK=2, V_FRONT=2.
- Reset, then enable=1: vsync high for exactly 3 cycles, href rises 5 cycles after the vsync rise, frame period is 47 cycles, and frame_done pulses on cycle 47.
- pattern_sel=0: line 0 bytes are FF FF FF E0 07 FF 07 E0 F8 1F F8 00 00 1F 00 00, with href high for 16 cycles and dvp_d = 00 during blanking.
- pattern_sel=2: line 1 bytes are 01 00, 01 01, … 01 07.
- pattern_sel changed from 0 to 3 mid-frame: the current frame stays colour bars; the next frame is solid_rgb=0xABCD, giving AB CD repeated.
- enable dropped during line 0: the frame completes, frame_cnt increments 0→1, busy falls after VFRONT, and no second vsync appears.
- sys_rst asserted mid-LINE: all outputs are 0 on the next edge and frame_cnt = 0; with enable held high, a new frame starts with vsync high from the second cycle after reset deasserts.

Source files
------------

// File: rtl/dvp_pkg.sv
// Shared types and constants for the synthetic DVP frame source:
// FSM states, pattern codes and the RGB565 colour-bar palette.
package dvp_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VSYNC  = 3'd1,
    VBACK  = 3'd2,
    LINE   = 3'd3,
    HBLANK = 3'd4,
    VFRONT = 3'd5
  } dvp_state_t;

  localparam logic [1:0] PAT_BARS  = 2'd0;
  localparam logic [1:0] PAT_XRAMP = 2'd1;
  localparam logic [1:0] PAT_CNT   = 2'd2;
  localparam logic [1:0] PAT_SOLID = 2'd3;

  localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
  localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
  localparam logic [15:0] BAR_CYAN    = 16'h07FF;
  localparam logic [15:0] BAR_GREEN   = 16'h07E0;
  localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
  localparam logic [15:0] BAR_RED     = 16'hF800;
  localparam logic [15:0] BAR_BLUE    = 16'h001F;
  localparam logic [15:0] BAR_BLACK   = 16'h0000;

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return BAR_WHITE;
      3'd1:    return BAR_YELLOW;
      3'd2:    return BAR_CYAN;
      3'd3:    return BAR_GREEN;
      3'd4:    return BAR_MAGENTA;
      3'd5:    return BAR_RED;
      3'd6:    return BAR_BLUE;
      default: return BAR_BLACK;
    endcase
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dvp_pixel_src.sv
// Combinational pattern generator: maps (pattern, x, y, solid) to one
// RGB565 pixel.
module dvp_pixel_src
  import dvp_pkg::*;
#(
  parameter int H_ACTIVE = 640
) (
  input  logic [1:0]  pattern,
  input  logic [15:0] x,
  input  logic [7:0]  y,
  input  logic [15:0] solid,
  output logic [15:0] pixel
);

  localparam int BAR_W = H_ACTIVE / 8;

  logic [2:0] bar_idx;

  always_comb begin
    bar_idx = 3'(x / 16'(BAR_W));
    pixel   = 16'h0000;
    case (pattern)
      PAT_BARS:  pixel = bar_color(bar_idx);
      PAT_XRAMP: pixel = x;
      PAT_CNT:   pixel = {y, x[7:0]};
      PAT_SOLID: pixel = solid;
      default:   pixel = 16'h0000;
    endcase
  end

endmodule

// File: rtl/dvp_frame_gen.sv
// Synthetic OV5640-style DVP source: frame timing FSM plus registered
// vsync/href/byte outputs carrying RGB565 test patterns, high byte first.
module dvp_frame_gen
  import dvp_pkg::*;
#(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int H_BLANK   = 144,
  parameter int VSYNC_LEN = 8,
  parameter int V_BACK    = 32,
  parameter int V_FRONT   = 16
) (
  input  logic        clk_25m,
  input  logic        sys_rst,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [15:0] solid_rgb,
  output logic        dvp_vsync,
  output logic        dvp_href,
  output logic [7:0]  dvp_d,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);

  localparam int LINE_LEN = 2 * H_ACTIVE;
  localparam int PH_MAX   = imax(imax(imax(LINE_LEN, H_BLANK), imax(VSYNC_LEN, V_BACK)), V_FRONT);
  localparam int PH_W     = cnt_w(PH_MAX);
  localparam int Y_W      = cnt_w(V_ACTIVE);

  dvp_state_t      state_q, state_d;
  logic [PH_W-1:0] ph_q, ph_d;
  logic [Y_W-1:0]  y_q, y_d;
  logic            frame_end;
  logic [1:0]      pat_q;
  logic [15:0]     solid_q;
  logic [15:0]     pixel;

  // ph counts cycles spent in the current state; in LINE it is the byte index.
  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q + 1'b1;
    y_d       = y_q;
    frame_end = 1'b0;
    case (state_q)
      IDLE: begin
        ph_d = '0;
        y_d  = '0;
        if (enable) state_d = VSYNC;
      end
      VSYNC: begin
        if (ph_q == PH_W'(VSYNC_LEN - 1)) begin
          state_d = VBACK;
          ph_d    = '0;
        end
      end
      VBACK: begin
        if (ph_q == PH_W'(V_BACK - 1)) begin
          state_d = LINE;
          ph_d    = '0;
          y_d     = '0;
        end
      end
      LINE: begin
        if (ph_q == PH_W'(LINE_LEN - 1)) begin
          state_d = HBLANK;
          ph_d    = '0;
        end
      end
      HBLANK: begin
        if (ph_q == PH_W'(H_BLANK - 1)) begin
          ph_d = '0;
          if (y_q < Y_W'(V_ACTIVE - 1)) begin
            state_d = LINE;
            y_d     = y_q + 1'b1;
          end else begin
            state_d = VFRONT;
          end
        end
      end
      VFRONT: begin
        if (ph_q == PH_W'(V_FRONT - 1)) begin
          ph_d      = '0;
          frame_end = 1'b1;
          state_d   = enable ? VSYNC : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        ph_d    = '0;
        y_d     = '0;
      end
    endcase
  end

  // Pixel is computed from next-state coordinates so the byte lands in the
  // same register stage as href and vsync.
  dvp_pixel_src #(
    .H_ACTIVE(H_ACTIVE)
  ) u_pixel_src (
    .pattern(pat_q),
    .x      (16'(ph_d >> 1)),
    .y      (8'(y_d)),
    .solid  (solid_q),
    .pixel  (pixel)
  );

  always_ff @(posedge clk_25m) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      ph_q       <= '0;
      y_q        <= '0;
      pat_q      <= PAT_BARS;
      solid_q    <= 16'h0000;
      dvp_vsync  <= 1'b0;
      dvp_href   <= 1'b0;
      dvp_d      <= 8'h00;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= 16'h0000;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      y_q     <= y_d;
      if (state_d == VSYNC && state_q != VSYNC) begin
        pat_q   <= pattern_sel;
        solid_q <= solid_rgb;
      end
      dvp_vsync  <= (state_d == VSYNC);
      dvp_href   <= (state_d == LINE);
      dvp_d      <= (state_d == LINE) ? (ph_d[0] ? pixel[7:0] : pixel[15:8]) : 8'h00;
      busy       <= (state_d != IDLE);
      frame_done <= (state_d == VFRONT) && (ph_d == PH_W'(V_FRONT - 1));
      if (frame_end) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_dvp_frame_gen.sv
// Self-checking bench for dvp_frame_gen with a small frame geometry:
// byte stream checked through an expected queue, timing checked directly.
module tb_dvp_frame_gen;

  localparam int H_ACTIVE  = 8;
  localparam int V_ACTIVE  = 2;
  localparam int H_BLANK   = 4;
  localparam int VSYNC_LEN = 3;
  localparam int V_BACK    = 2;
  localparam int V_FRONT   = 2;

  logic        clk_25m = 1'b0;
  logic        sys_rst = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [15:0] solid_rgb = 16'h0000;
  logic        dvp_vsync;
  logic        dvp_href;
  logic [7:0]  dvp_d;
  logic        busy;
  logic        frame_done;
  logic [15:0] frame_cnt;

  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  dvp_frame_gen #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .H_BLANK  (H_BLANK),
    .VSYNC_LEN(VSYNC_LEN),
    .V_BACK   (V_BACK),
    .V_FRONT  (V_FRONT)
  ) dut (
    .clk_25m    (clk_25m),
    .sys_rst    (sys_rst),
    .enable     (enable),
    .pattern_sel(pattern_sel),
    .solid_rgb  (solid_rgb),
    .dvp_vsync  (dvp_vsync),
    .dvp_href   (dvp_href),
    .dvp_d      (dvp_d),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt)
  );

  // clock
  always #5 clk_25m = ~clk_25m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_pixel(input int pat, input int x, input int y,
                                              input logic [15:0] solid);
    logic [15:0] bars [8];
    bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    case (pat)
      0:       return bars[x / (H_ACTIVE / 8)];
      1:       return 16'(x);
      2:       return {8'(y), 8'(x)};
      default: return solid;
    endcase
  endfunction

  task automatic push_frame(input int pat, input logic [15:0] solid);
    logic [15:0] px;
    for (int y = 0; y < V_ACTIVE; y++)
      for (int x = 0; x < H_ACTIVE; x++) begin
        px = model_pixel(pat, x, y, solid);
        exp_q.push_back(px[15:8]);
        exp_q.push_back(px[7:0]);
      end
  endtask

  // Watches one frame from the next negedge on; cycle 1 is that negedge.
  task automatic observe(input bit drop_en, input bit chg_pat,
                         output int vs_rise, output int vs_len,
                         output int href_rise, output int done_c,
                         output logic [15:0] fc_first);
    vs_rise = -1; vs_len = 0; href_rise = -1; done_c = -1; fc_first = 16'hxxxx;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk_25m);
      if (c == 1) fc_first = frame_cnt;
      if (dvp_vsync) begin
        if (vs_rise < 0) vs_rise = c;
        vs_len++;
      end
      if (dvp_href && href_rise < 0) begin
        href_rise = c;
        if (drop_en) enable = 1'b0;
        if (chg_pat) begin
          pattern_sel = 2'd3;
          solid_rgb   = 16'hABCD;
        end
      end
      if (frame_done) begin
        done_c = c;
        break;
      end
    end
  endtask

  // scoreboard monitor
  always @(negedge clk_25m) begin
    if (dvp_href) begin
      if (exp_q.size() == 0) begin
        check("unexpected_byte", {24'h0, dvp_d}, 32'hFFFF_FFFF);
      end else begin
        check("dvp_d", {24'h0, dvp_d}, {24'h0, exp_q.pop_front()});
      end
    end else begin
      check("blank_d", {24'h0, dvp_d}, 32'h0);
    end
  end

  initial begin
    int vs_rise, vs_len, href_rise, done_c, vs_seen;
    logic [15:0] fc_first;

    // reset
    repeat (3) @(negedge clk_25m);
    check("rst_vsync", dvp_vsync, 0);
    check("rst_href", dvp_href, 0);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_cnt", frame_cnt, 0);

    // frame 1: colour bars, pattern switched to solid mid-frame
    push_frame(0, 16'h0000);
    sys_rst = 1'b0; enable = 1'b1; pattern_sel = 2'd0;
    observe(1'b0, 1'b1, vs_rise, vs_len, href_rise, done_c, fc_first);
    check("f1_vs_rise", vs_rise, 1);
    check("f1_vs_len", vs_len, VSYNC_LEN);
    check("f1_href_rise", href_rise, 6);
    check("f1_done", done_c, 47);
    check("f1_cnt_first", fc_first, 0);

    // frame 2: back-to-back, solid, enable dropped during line 0
    push_frame(3, 16'hABCD);
    observe(1'b1, 1'b0, vs_rise, vs_len, href_rise, done_c, fc_first);
    check("f2_vs_rise", vs_rise, 1);
    check("f2_cnt_first", fc_first, 1);
    check("f2_href_rise", href_rise, 6);
    check("f2_done", done_c, 47);
    @(negedge clk_25m);
    check("f2_busy_after", busy, 0);
    check("f2_cnt_after", frame_cnt, 2);
    vs_seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_25m);
      if (dvp_vsync) vs_seen++;
    end
    check("f2_no_vsync", vs_seen, 0);

    // frame 3: {y,x} counter
    push_frame(2, 16'h0000);
    pattern_sel = 2'd2; enable = 1'b1;
    observe(1'b1, 1'b0, vs_rise, vs_len, href_rise, done_c, fc_first);
    check("f3_vs_rise", vs_rise, 1);
    check("f3_done", done_c, 47);
    @(negedge clk_25m);
    check("f3_cnt", frame_cnt, 3);
    check("f3_q_empty", exp_q.size(), 0);

    // reset asserted mid-LINE
    push_frame(0, 16'h0000);
    pattern_sel = 2'd0; enable = 1'b1;
    for (int i = 0; i < 100 && !dvp_href; i++) @(negedge clk_25m);
    check("mid_href_seen", dvp_href, 1);
    repeat (3) @(negedge clk_25m);
    sys_rst = 1'b1;
    @(negedge clk_25m);
    check("mid_rst_vsync", dvp_vsync, 0);
    check("mid_rst_href", dvp_href, 0);
    check("mid_rst_d", dvp_d, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", frame_done, 0);
    check("mid_rst_cnt", frame_cnt, 0);
    exp_q.delete();
    push_frame(0, 16'h0000);
    sys_rst = 1'b0;
    @(negedge clk_25m);
    check("post_rst_vsync", dvp_vsync, 1);
    check("post_rst_busy", busy, 1);
    enable = 1'b0;
    for (int i = 0; i < 200 && busy; i++) @(negedge clk_25m);
    check("post_rst_idle", busy, 0);
    check("post_rst_cnt", frame_cnt, 1);
    check("final_q_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
